// File: rtl/hazard_stall_unit.sv
//-----------------------------------------------------------------------------
// hazard_stall_unit
//
// Pipeline hazard and stall controller for a classic 5-stage in-order core.
// It detects load-use hazards between IF/ID and ID/EX and handles taken-branch
// flushes. Optionally it holds the front end while a multi-cycle mult/div
// occupies EX. It also keeps a saturating count of front-end stall cycles.
//
// Optional feature: define MULDIV_STALL_EN to compile in the MD_BUSY state,
// its down-counter and the muldiv_done pulse. Without it, muldiv_start is
// ignored, the FSM stays in RUN and muldiv_done is tied low.
//
// Parameters
//   MULDIV_CYCLES  EX occupancy of a mult/div in cycles (2..255)
//
// Ports
//   clk           in   clock, all state updates on the rising edge
//   rst           in   asynchronous active-high reset
//   rs_id, rt_id  in   source registers of the IF/ID instruction
//   rt_ex         in   destination register of the load in ID/EX
//   mem_read_ex   in   ID/EX instruction is a load
//   branch_taken  in   branch resolved taken in EX this cycle
//   muldiv_start  in   mult/div entered EX this cycle
//   pc_write      out  PC update enable
//   ifid_write    out  IF/ID load enable
//   ifid_flush    out  zero the IF/ID register
//   idex_bubble   out  zero the control fields entering ID/EX
//   muldiv_done   out  one-cycle pulse on the first RUN cycle after MD_BUSY
//   stall_cycles  out  saturating count of cycles with pc_write low
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module hazard_stall_unit #(
    parameter int unsigned MULDIV_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs_id,
    input  logic [4:0]  rt_id,
    input  logic [4:0]  rt_ex,
    input  logic        mem_read_ex,
    input  logic        branch_taken,
    input  logic        muldiv_start,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        muldiv_done,
    output logic [15:0] stall_cycles
);

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

`ifdef MULDIV_STALL_EN
    localparam bit MdEnable = 1'b1;
`else
    localparam bit MdEnable = 1'b0;
`endif

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] stall_q;
    logic        loadUse;

    // Register zero is hardwired, so a load targeting it never creates a hazard.
    assign loadUse = (state_q == RUN) && mem_read_ex && (rt_ex != 5'd0) &&
                     ((rt_ex == rs_id) || (rt_ex == rt_id));

    // Pipeline control and next state. A taken branch outranks a load-use
    // hazard because the stalled instruction is squashed anyway. The counter
    // is loaded with MULDIV_CYCLES-2 because the start cycle itself is spent
    // in RUN, and the count of 0 is still a busy cycle.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        state_d     = state_q;
        cnt_d       = cnt_q;
        case (state_q)
            RUN: begin
                if (branch_taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (loadUse) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end else if (MdEnable && muldiv_start) begin
                    state_d = MD_BUSY;
                    cnt_d   = 8'(MULDIV_CYCLES - 2);
                end
            end
            MD_BUSY: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
                if (cnt_q == 8'd0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef MULDIV_STALL_EN
    logic done_q;

    // Busy counter and the completion pulse, which fires on the cycle after
    // the last busy cycle, i.e. the first cycle back in RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= 8'd0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= (state_q == MD_BUSY) && (cnt_q == 8'd0);
        end
    end

    assign muldiv_done = done_q;
`else
    logic unusedBits;

    assign cnt_q       = 8'd0;
    assign muldiv_done = 1'b0;
    assign unusedBits  = ^cnt_d;
`endif

    // Stall counter sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= 16'd0;
        end else if (!pc_write && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
//-----------------------------------------------------------------------------
// tb_hazard_stall_unit
//
// Directed-vector bench for hazard_stall_unit. Each vector carries its
// hand-computed expected outputs into a queue; a monitor on the falling edge
// pops one entry per active vector and compares it with the DUT outputs.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_hazard_stall_unit;

    logic        clk;
    logic        rst;
    logic [4:0]  rsId, rtId, rtEx;
    logic        memReadEx, branchTaken, muldivStart;
    logic        pcWrite, ifidWrite, ifidFlush, idexBubble, muldivDone;
    logic [15:0] stallCycles;

    typedef struct packed {
        logic [3:0]  ctl;
        logic        done;
        logic [15:0] stall;
    } exp_t;

    exp_t expQ[$];
    logic vecValid;
    int   vectorCount;
    int   missCount;

    hazard_stall_unit #(.MULDIV_CYCLES(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .rs_id        (rsId),
        .rt_id        (rtId),
        .rt_ex        (rtEx),
        .mem_read_ex  (memReadEx),
        .branch_taken (branchTaken),
        .muldiv_start (muldivStart),
        .pc_write     (pcWrite),
        .ifid_write   (ifidWrite),
        .ifid_flush   (ifidFlush),
        .idex_bubble  (idexBubble),
        .muldiv_done  (muldivDone),
        .stall_cycles (stallCycles)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one vector for one cycle and queues its expected response.
    // ctlV is {pc_write, ifid_write, ifid_flush, idex_bubble}.
    task automatic applyStimulus(input logic rstV, input logic [4:0] rsV,
                                 input logic [4:0] rtV, input logic [4:0] rtExV,
                                 input logic memV, input logic brV, input logic mdV,
                                 input logic [3:0] ctlV, input logic doneV,
                                 input logic [15:0] stallV);
        exp_t e;
        rst         = rstV;
        rsId        = rsV;
        rtId        = rtV;
        rtEx        = rtExV;
        memReadEx   = memV;
        branchTaken = brV;
        muldivStart = mdV;
        e.ctl       = ctlV;
        e.done      = doneV;
        e.stall     = stallV;
        expQ.push_back(e);
        vecValid    = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Compares DUT outputs against one expected entry.
    task automatic checkOutput(input exp_t e);
        logic [3:0] ctlAct;
        ctlAct = {pcWrite, ifidWrite, ifidFlush, idexBubble};
        vectorCount++;
        if (ctlAct !== e.ctl || muldivDone !== e.done || stallCycles !== e.stall) begin
            missCount++;
            $display("[TB] FAIL vec%0d ctl{pc,ifw,fl,bub} got %b want %b, done got %b want %b, stall got %h want %h",
                     vectorCount, ctlAct, e.ctl, muldivDone, e.done, stallCycles, e.stall);
        end
    endtask

    // Monitor: one comparison per active vector, on the falling edge.
    always @(negedge clk) begin
        if (vecValid) begin
            if (expQ.size() == 0) begin
                vectorCount++;
                missCount++;
                $display("[TB] FAIL scoreboard underflow at %0t", $time);
            end else begin
                checkOutput(expQ.pop_front());
            end
        end
    end

    initial begin
        vectorCount = 0;
        missCount   = 0;
        vecValid    = 1'b0;
        rst         = 1'b1;
        rsId        = 5'd0;
        rtId        = 5'd0;
        rtEx        = 5'd0;
        memReadEx   = 1'b0;
        branchTaken = 1'b0;
        muldivStart = 1'b0;
        @(posedge clk);
        #1;

        // Reset state and basic hazards.
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'b1100, 1'b0, 16'd0);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'b1100, 1'b0, 16'd0);
        applyStimulus(1'b0, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b0, 16'd0);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'b1100, 1'b0, 16'd1);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 4'b1100, 1'b0, 16'd1);
        applyStimulus(1'b0, 5'd1, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b0, 16'd1);
        applyStimulus(1'b0, 5'd9, 5'd9, 5'd9, 1'b0, 1'b0, 1'b0, 4'b1100, 1'b0, 16'd2);
        applyStimulus(1'b0, 5'd7, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b0, 16'd2);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'b1100, 1'b0, 16'd2);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 4'b1111, 1'b0, 16'd2);

        // muldiv_start coinciding with a hazard or a branch is ignored.
        applyStimulus(1'b0, 5'd3, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 4'b0001, 1'b0, 16'd2);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 4'b1111, 1'b0, 16'd3);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'b1100, 1'b0, 16'd3);

`ifdef MULDIV_STALL_EN
        // Full mult/div: 7 busy cycles, branch/start ignored while busy.
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 4'b1100, 1'b0, 16'd3);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, i[0], i[1], 4'b0001, 1'b0,
                          16'(3 + i));
        end
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'b1100, 1'b1, 16'd10);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'b1100, 1'b0, 16'd10);

        // Reset arriving on the third busy cycle.
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 4'b1100, 1'b0, 16'd10);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 16'd10);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 16'd11);
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'b1100, 1'b0, 16'd0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'b1100, 1'b0, 16'd0);
        end
`else
        // Without the mult/div feature, muldiv_start has no effect.
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 4'b1100, 1'b0, 16'd3);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'b1100, 1'b0, 16'd3);
        applyStimulus(1'b0, 5'd4, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b0, 16'd3);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'b1100, 1'b0, 16'd4);
`endif

        // Saturation: reset, then 65534 unchecked hazard cycles.
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'b1100, 1'b0, 16'd0);
        vecValid    = 1'b0;
        rst         = 1'b0;
        rsId        = 5'd6;
        rtEx        = 5'd6;
        memReadEx   = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        applyStimulus(1'b0, 5'd6, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b0, 16'hFFFE);
        applyStimulus(1'b0, 5'd6, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b0, 16'hFFFF);
        applyStimulus(1'b0, 5'd6, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b0, 16'hFFFF);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'b1100, 1'b0, 16'hFFFF);

        vecValid = 1'b0;
        @(posedge clk);
        #1;
        if (expQ.size() != 0) begin
            missCount++;
            $display("[TB] FAIL scoreboard leftover entries got %0d want 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
